// File: rtl/signed_clip_arbiter.sv
// signed_clip_arbiter: round-robin shared 16->8 bit signed saturating narrower with registered valid/ready output and saturation counter
// Ports: clk/rst_n (sync active-low); i_req_valid/i_req_data (NREQ packed 16-bit samples) in, o_req_ready one-hot accept;
//        o_out_valid/i_out_ready handshake with o_out_data, o_out_id, o_out_sat; i_cnt_clr clears o_sat_cnt (sticky at max)
module signed_clip_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*16-1:0] i_req_data,
  output logic [NREQ-1:0]    o_req_ready,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [7:0]         o_out_data,
  output logic [IDW-1:0]     o_out_id,
  output logic               o_out_sat,
  input  logic               i_cnt_clr,
  output logic [CNTW-1:0]    o_sat_cnt
);
  logic            r_valid, r_sat;
  logic [7:0]      r_data;
  logic [IDW-1:0]  r_id, r_ptr, w_grant;
  logic [CNTW-1:0] r_cnt;
  logic [15:0]     w_x;
  logic            w_accept, w_sat, w_inc;
  logic [7:0]      w_clip;
  always_comb begin
    w_grant = '0;
    for (int k = NREQ-1; k >= 0; k--)
      if (i_req_valid[(int'(r_ptr)+k)%NREQ]) w_grant = IDW'((int'(r_ptr)+k)%NREQ);
  end
  assign w_accept    = rst_n && |i_req_valid && (!r_valid || i_out_ready);
  assign o_req_ready = w_accept ? NREQ'(1) << w_grant : '0;
  assign w_x         = i_req_data[{w_grant, 4'b0} +: 16];
  assign w_sat       = !(&w_x[15:7] || ~|w_x[15:7]);
  assign w_clip      = w_sat ? (w_x[15] ? 8'h80 : 8'h7F) : w_x[7:0];
  assign w_inc       = w_accept && w_sat;
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= '0;
      r_sat   <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= w_clip;
        r_id    <= w_grant;
        r_sat   <= w_sat;
        r_ptr   <= (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + 1'b1;
      end else if (i_out_ready) r_valid <= 1'b0;
      if (i_cnt_clr) r_cnt <= CNTW'(w_inc);
      else if (w_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
  assign o_out_id    = r_id;
  assign o_out_sat   = r_sat;
  assign o_sat_cnt   = r_cnt;
endmodule

// File: tb/tb_signed_clip_arbiter.sv
// tb_signed_clip_arbiter: directed table-driven bench for signed_clip_arbiter
module tb_signed_clip_arbiter;
  logic        clk = 0, rst_n = 0;
  logic [3:0]  req_valid = '0, req_ready;
  logic [63:0] req_data = '0;
  logic        out_valid, out_ready = 1, out_sat, cnt_clr = 0;
  logic [7:0]  out_data;
  logic [1:0]  out_id;
  logic [15:0] sat_cnt;
  int          total = 0, bad = 0;
  typedef struct { logic [15:0] x; logic [7:0] y; logic s; } vec_t;
  vec_t tv[11];
  signed_clip_arbiter #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_id(out_id), .o_out_sat(out_sat),
    .i_cnt_clr(cnt_clr), .o_sat_cnt(sat_cnt));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic id_data;
    for (int i = 0; i < 4; i++) req_data[16*i +: 16] = 16'h0010 * 16'(i) + 16'h0001;
  endtask
  initial begin
    int esat;
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    tv[0]  = '{16'h0070, 8'h70, 1'b0};
    tv[1]  = '{16'h2000, 8'h7F, 1'b1};
    tv[2]  = '{16'h9000, 8'h80, 1'b1};
    tv[3]  = '{16'hFF80, 8'h80, 1'b0};
    tv[4]  = '{16'h007F, 8'h7F, 1'b0};
    tv[5]  = '{16'hFF7F, 8'h80, 1'b1};
    tv[6]  = '{16'h0080, 8'h7F, 1'b1};
    tv[7]  = '{16'hFFFF, 8'hFF, 1'b0};
    tv[8]  = '{16'h8000, 8'h80, 1'b1};
    tv[9]  = '{16'h0000, 8'h00, 1'b0};
    tv[10] = '{16'h7FFF, 8'h7F, 1'b1};
    // T1 reset with all requesters active
    id_data();
    req_valid = 4'hF;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_cnt", 32'(sat_cnt), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_id", 32'(out_id), 0);
    rst_n = 1;
    #1;
    chk("first_ready", 32'(req_ready), 32'h1);
    // T3 round-robin at full rate
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_valid", 32'(out_valid), 1);
      chk("rr_id", 32'(out_id), 32'(seq[i]));
      chk("rr_data", 32'(out_data), 32'({seq[i], 4'h1}));
    end
    req_valid = 4'b1001;
    #1;
    chk("rr_ready3", 32'(req_ready), 32'h8);
    tick();
    chk("rr_id3", 32'(out_id), 3);
    chk("rr_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("rr_id0", 32'(out_id), 0);
    // T2 clip table on requester 0
    req_valid = 4'b0001;
    esat = 0;
    for (int i = 0; i < 11; i++) begin
      req_data[15:0] = tv[i].x;
      tick();
      esat += int'(tv[i].s);
      chk("clip_valid", 32'(out_valid), 1);
      chk("clip_id", 32'(out_id), 0);
      chk("clip_data", 32'(out_data), 32'(tv[i].y));
      chk("clip_sat", 32'(out_sat), 32'(tv[i].s));
      if (i == 4) chk("clip_cnt5", 32'(sat_cnt), 2);
    end
    chk("clip_cnt", 32'(sat_cnt), 32'(esat));
    req_valid = '0;
    tick();
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_data", 32'(out_data), 32'h7F);
    chk("idle_sat", 32'(out_sat), 1);
    // T4 backpressure; pointer now at 1
    id_data();
    out_ready = 0;
    req_valid = 4'hF;
    #1;
    chk("bp_ready_first", 32'(req_ready), 32'h2);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", 32'(req_ready), 0);
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_id", 32'(out_id), 1);
      chk("bp_data", 32'(out_data), 32'h11);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'h4);
    tick();
    chk("bp_next_id", 32'(out_id), 2);
    chk("bp_next_data", 32'(out_data), 32'h21);
    tick();
    chk("bp_after_id", 32'(out_id), 3);
    // T6 reset while stalled with rr_ptr=2
    req_valid = 4'b0010;
    tick();
    chk("t6_id", 32'(out_id), 1);
    out_ready = 0;
    req_valid = 4'hF;
    rst_n = 0;
    tick();
    chk("t6_valid", 32'(out_valid), 0);
    chk("t6_cnt", 32'(sat_cnt), 0);
    chk("t6_id_rst", 32'(out_id), 0);
    rst_n = 1;
    out_ready = 1;
    #1;
    chk("t6_ptr", 32'(req_ready), 32'h1);
    // T5 counter saturation and clear
    req_valid = 4'b0001;
    req_data[15:0] = 16'h8000;
    for (int i = 0; i < 65535; i++) tick();
    chk("cnt_full", 32'(sat_cnt), 32'hFFFF);
    tick();
    chk("cnt_sticky", 32'(sat_cnt), 32'hFFFF);
    cnt_clr = 1;
    tick();
    chk("cnt_clr_inc", 32'(sat_cnt), 1);
    req_valid = '0;
    tick();
    chk("cnt_clr_only", 32'(sat_cnt), 0);
    cnt_clr = 0;
    req_valid = 4'b0001;
    req_data[15:0] = 16'h0001;
    tick();
    chk("cnt_noclip", 32'(sat_cnt), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
